uni_shift_reg_param: RTL
========================

// Module: uni_shift_reg_param
// PURPOSE
//  Parametrised universal shift register, successor to the fixed 8-bit version.
//  - Adds generic WIDTH, separate left/right serial inputs, rotates, arithmetic right shift, sync clear.
//  - Adds a shift counter with a frame-done pulse, so a loaded word can be serialised without an external counter.
//  - Used as the serialiser/deserialiser core in datapath and serial-link blocks.
// PARAMETERS
//  WIDTH        8    register width in bits; legal range >= 2
//  RESET_VALUE  0    WIDTH-bit value loaded into the register on reset
//  localparam CW = $clog2(WIDTH)   counter width
// PORTS
//  clock            input   1      single clock; all state updates on its rising edge
//  reset_n          input   1      asynchronous, active-low reset
//  enable           input   1      1: execute mode this cycle; 0: freeze register and counter
//  mode             input   3      operation select, see BEHAVIOUR
//  data_input       input   WIDTH  parallel load data
//  serial_in_left   input   1      bit entering the MSB on SHR
//  serial_in_right  input   1      bit entering the LSB on SHL
//  parallel_output  output  WIDTH  current register contents q
//  shift_output     output  1      serial bit out (combinational from q and mode)
//  shift_count      output  CW     shifts completed in the current frame
//  frame_done       output  1      one-cycle pulse after the WIDTH-th shift of a frame
// BEHAVIOUR
//  Reset (reset_n=0, asynchronous, immediate):
//   - q=RESET_VALUE, shift_count=0, frame_done=0; this holds mid-operation and overrides everything.
//  Modes, applied at the rising edge when enable=1:
//   - 000 HOLD   q unchanged
//   - 001 SHL    q <= {q[W-2:0], serial_in_right}
//   - 010 SHR    q <= {serial_in_left, q[W-1:1]}
//   - 011 LOAD   q <= data_input
//   - 100 ROTL   q <= {q[W-2:0], q[W-1]}
//   - 101 ROTR   q <= {q[0], q[W-1:1]}
//   - 110 ASR    q <= {q[W-1], q[W-1:1]}
//   - 111 CLEAR  q <= 0 (synchronous)
//  enable=0: q and shift_count hold, whatever the mode.
//  shift_output: q[0] when mode is SHR, ROTR or ASR; q[W-1] for every other mode. No added latency.
//  Counter:
//   - SHL, SHR, ROTL, ROTR and ASR each count as one shift when enabled.
//   - LOAD or CLEAR sets shift_count to 0. HOLD does not change it.
//   - On a shift with shift_count==WIDTH-1: shift_count wraps to 0 and frame_done is registered high.
//  frame_done:
//   - High for exactly the one cycle after the completing edge, then cleared on the next edge even if enable=0.
//   - Back-to-back frames give one pulse every WIDTH shifts.
//   - A LOAD or CLEAR on the cycle after a completing shift does not suppress the pending pulse.
//  Mixing shift directions within a frame still counts every shift; direction is not tracked.
//  Latency: one cycle from mode/enable to parallel_output.
// STRUCTURE
//  usr_defs.vh (shared include): mode encodings USR_HOLD..USR_CLEAR; also used by the serial-link blocks.
//  Sub-module usr_bit_cell:
//   - 8:1 next-state mux plus async-reset flop, with inputs own/left/right neighbour, load bit, serial in and clear.
//   - Instantiated WIDTH times in a generate loop.
//  The counter and frame_done flop live in the top module.
// TESTING (WIDTH=8, RESET_VALUE=0 unless stated)
//  1. Reset -> q=8'h00, shift_count=0, frame_done=0.
//     Then rebuild with RESET_VALUE=8'h3C -> q=8'h3C.
//  2. LOAD 8'hA5, then SHL x3 with serial_in_right=1.
//     -> q = 4B, 97, 2F.
//     -> shift_output before each shift = 1, 0, 1.
//     -> shift_count = 1, 2, 3.
//  3. LOAD 8'h81, then ROTR x8.
//     -> q=8'h81 after the 8th shift, shift_count=0.
//     -> frame_done high for exactly one cycle after the 8th edge.
//  4. LOAD 8'h80, then ASR x3 -> q = C0, E0, F0.
//     Then SHR with serial_in_left=0 -> q=8'h78.
//  5. Mode SHL with enable=0 for 5 cycles -> no change.
//     Then CLEAR -> q=0, shift_count=0.
//  6. Drop reset_n mid-cycle after 4 shifts -> outputs go to reset values before the next edge.
//     After release, a LOAD then 8 shifts produces exactly one frame_done pulse.

Source files
------------

// File: rtl/uni_shift_reg_param_pkg.sv
// Shared definitions for the universal shift register: operation encodings and mode helpers.
package uni_shift_reg_param_pkg;

   localparam int unsigned MODE_W = 3;

   typedef enum logic [MODE_W-1:0] {
      USR_HOLD  = 3'b000,
      USR_SHL   = 3'b001,
      USR_SHR   = 3'b010,
      USR_LOAD  = 3'b011,
      USR_ROTL  = 3'b100,
      USR_ROTR  = 3'b101,
      USR_ASR   = 3'b110,
      USR_CLEAR = 3'b111
   } usr_mode_e;

   // Any mode that moves bits advances the frame counter.
   function automatic logic is_shift(input usr_mode_e m);
      return (m == USR_SHL) || (m == USR_SHR) || (m == USR_ROTL) ||
             (m == USR_ROTR) || (m == USR_ASR);
   endfunction

   // Right-moving modes serialise from the LSB, everything else from the MSB.
   function automatic logic shifts_right(input usr_mode_e m);
      return (m == USR_SHR) || (m == USR_ROTR) || (m == USR_ASR);
   endfunction

endpackage

// File: rtl/uni_shift_reg_param_bit_cell.sv
// One register bit: next-state mux over the eight modes plus its async-reset flop.
module uni_shift_reg_param_bit_cell
   import uni_shift_reg_param_pkg::*;
#(
   parameter bit IS_LSB  = 1'b0,
   parameter bit IS_MSB  = 1'b0,
   parameter bit RST_BIT = 1'b0
) (
   input  logic      clock,
   input  logic      reset_n,
   input  logic      enable,
   input  usr_mode_e mode,
   input  logic      upper,
   input  logic      lower,
   input  logic      load_bit,
   input  logic      serial_in,
   output logic      q
);

   logic d_c;

   // upper/lower already carry the wrap-around neighbour at the edge cells.
   always_comb begin
      d_c = q;
      case (mode)
         USR_HOLD:  d_c = q;
         USR_SHL:   d_c = IS_LSB ? serial_in : lower;
         USR_SHR:   d_c = IS_MSB ? serial_in : upper;
         USR_LOAD:  d_c = load_bit;
         USR_ROTL:  d_c = lower;
         USR_ROTR:  d_c = upper;
         USR_ASR:   d_c = IS_MSB ? q : upper;
         USR_CLEAR: d_c = 1'b0;
         default:   d_c = q;
      endcase
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         q <= RST_BIT;
      end else if (enable) begin
         q <= d_c;
      end
   end

endmodule

// File: rtl/uni_shift_reg_param.sv
// Parametrised universal shift register with per-frame shift counter and frame-done pulse.
module uni_shift_reg_param
   import uni_shift_reg_param_pkg::*;
#(
   parameter int unsigned      WIDTH       = 8,
   parameter logic [WIDTH-1:0] RESET_VALUE = '0,
   localparam int unsigned     CW          = $clog2(WIDTH)
) (
   input  logic              clock,
   input  logic              reset_n,
   input  logic              enable,
   input  logic [2:0]        mode,
   input  logic [WIDTH-1:0]  data_input,
   input  logic              serial_in_left,
   input  logic              serial_in_right,
   output logic [WIDTH-1:0]  parallel_output,
   output logic              shift_output,
   output logic [CW-1:0]     shift_count,
   output logic              frame_done
);

   usr_mode_e        mode_c;
   logic [WIDTH-1:0] q;

   assign mode_c = usr_mode_e'(mode);

   for (genvar i = 0; i < WIDTH; i++) begin : g_cell
      logic upper;
      logic lower;
      logic ser;

      if (i == WIDTH - 1) begin : g_top
         assign upper = q[0];
      end else begin : g_mid_up
         assign upper = q[i+1];
      end

      if (i == 0) begin : g_bot
         assign lower = q[WIDTH-1];
         assign ser   = serial_in_right;
      end else if (i == WIDTH - 1) begin : g_msb
         assign lower = q[i-1];
         assign ser   = serial_in_left;
      end else begin : g_mid
         assign lower = q[i-1];
         assign ser   = 1'b0;
      end

      uni_shift_reg_param_bit_cell #(
         .IS_LSB  (i == 0),
         .IS_MSB  (i == WIDTH - 1),
         .RST_BIT (RESET_VALUE[i])
      ) u_cell (
         .clock     (clock),
         .reset_n   (reset_n),
         .enable    (enable),
         .mode      (mode_c),
         .upper     (upper),
         .lower     (lower),
         .load_bit  (data_input[i]),
         .serial_in (ser),
         .q         (q[i])
      );
   end

   assign parallel_output = q;
   assign shift_output    = shifts_right(mode_c) ? q[0] : q[WIDTH-1];

   // frame_done defaults low every edge so the pulse lasts one cycle regardless of enable.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         shift_count <= '0;
         frame_done  <= 1'b0;
      end else begin
         frame_done <= 1'b0;
         if (enable) begin
            if (is_shift(mode_c)) begin
               if (shift_count == CW'(WIDTH - 1)) begin
                  shift_count <= '0;
                  frame_done  <= 1'b1;
               end else begin
                  shift_count <= shift_count + CW'(1);
               end
            end else if ((mode_c == USR_LOAD) || (mode_c == USR_CLEAR)) begin
               shift_count <= '0;
            end
         end
      end
   end

endmodule
